angle_sensor_poller: RTL



---
 rtl/angle_sensor_poller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/angle_sensor_poller.sv
// rtl/angle_sensor_poller.sv - autonomous SPI poller for a bank of AS5047-class angle encoders
//
// Ports:
//   clock, reset           system clock, asynchronous active-high reset
//   address/read/readdata  register read port (readdata registered, one cycle latency)
//   write/writedata        register write port (only bit0 of word 16 is writable)
//   waitrequest            constant 0
//   angle_miso/mosi/sck    shared SPI bus, mode 1, 16-bit MSB-first frames
//   angle_ss_n_o           active-low chip select, one per sensor
module angle_sensor_poller #(
    parameter int NUMBER_OF_SENSORS = 9,
    parameter int CLOCK_DIVIDER     = 10,
    parameter int POLL_GAP_CYCLES   = 100
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [4:0]                   address,
    input  logic                         read,
    output logic [31:0]                  readdata,
    input  logic                         write,
    input  logic [31:0]                  writedata,
    output logic                         waitrequest,
    input  logic                         angle_miso,
    output logic                         angle_mosi,
    output logic                         angle_sck,
    output logic [NUMBER_OF_SENSORS-1:0] angle_ss_n_o
);
    localparam int GAP_CYCLES = (POLL_GAP_CYCLES < 1) ? 1 : POLL_GAP_CYCLES;
    localparam int CNT_MAX    = (CLOCK_DIVIDER > GAP_CYCLES) ? CLOCK_DIVIDER : GAP_CYCLES;
    localparam int CW         = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLOCK_DIVIDER - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LAST_INDEX = 4'(NUMBER_OF_SENSORS - 1);
    // Read ANGLECOM with the parity bit set.
    localparam logic [15:0]   COMMAND    = 16'hFFFF;

    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, DESELECT, GAP} state_t;

    state_t                       state, state_next;
    logic [CW-1:0]                count, count_next;
    logic [3:0]                   index, index_next;
    logic [3:0]                   bit_cnt, bit_cnt_next;
    logic [15:0]                  shreg, shreg_next;
    logic                         sck_next, mosi_next;
    logic [NUMBER_OF_SENSORS-1:0] ss_n_next;
    logic                         latch, sweep_done;

    logic                         enable;
    logic [31:0]                  sweep_count;
    logic [31:0]                  read_mux;
    logic [13:0]                  angle_reg [NUMBER_OF_SENSORS];
    logic [NUMBER_OF_SENSORS-1:0] error_reg, parity_reg, valid_reg, seen_reg;
    logic                         unused_wdata;

    assign waitrequest  = 1'b0;
    assign unused_wdata = ^writedata[31:1];

    always_comb begin
        state_next   = state;
        count_next   = count + 1'b1;
        index_next   = index;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        sck_next     = angle_sck;
        mosi_next    = angle_mosi;
        ss_n_next    = '1;
        latch        = 1'b0;
        sweep_done   = 1'b0;
        case (state)
            IDLE: begin
                count_next = '0;
                if (enable) begin
                    state_next = SELECT;
                    index_next = '0;
                end
            end
            SELECT: begin
                if (count == HALF_LAST) begin
                    state_next   = SHIFT;
                    count_next   = '0;
                    bit_cnt_next = 4'd15;
                    sck_next     = 1'b1;
                    mosi_next    = COMMAND[15];
                end
            end
            SHIFT: begin
                if (count == HALF_LAST) begin
                    count_next = '0;
                    if (angle_sck) begin
                        // Falling edge: capture MISO, which the sensor set up on the rising edge.
                        sck_next     = 1'b0;
                        shreg_next   = {shreg[14:0], angle_miso};
                        bit_cnt_next = bit_cnt - 4'd1;
                        if (bit_cnt == 4'd0) begin
                            state_next = DESELECT;
                            mosi_next  = 1'b0;
                        end
                    end else begin
                        sck_next  = 1'b1;
                        mosi_next = COMMAND[bit_cnt];
                    end
                end
            end
            DESELECT: begin
                // The last bit entered shreg on the edge that got us here.
                latch = (count == '0);
                if (count == HALF_LAST) begin
                    count_next = '0;
                    if (index == LAST_INDEX) begin
                        state_next = GAP;
                        sweep_done = 1'b1;
                    end else begin
                        state_next = SELECT;
                        index_next = index + 4'd1;
                    end
                end
            end
            GAP: begin
                if (count == GAP_LAST) begin
                    state_next = IDLE;
                    count_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == SELECT || state_next == SHIFT) begin
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                if (index_next == 4'(i)) ss_n_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            index        <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            angle_sck    <= 1'b0;
            angle_mosi   <= 1'b0;
            angle_ss_n_o <= '1;
        end else begin
            state        <= state_next;
            count        <= count_next;
            index        <= index_next;
            bit_cnt      <= bit_cnt_next;
            shreg        <= shreg_next;
            angle_sck    <= sck_next;
            angle_mosi   <= mosi_next;
            angle_ss_n_o <= ss_n_next;
        end
    end

    // Each response answers the previous command, so a sensor's first frame is never valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) angle_reg[i] <= '0;
            error_reg   <= '0;
            parity_reg  <= '0;
            valid_reg   <= '0;
            seen_reg    <= '0;
            sweep_count <= '0;
        end else begin
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                if (latch && index == 4'(i)) begin
                    angle_reg[i]  <= shreg[13:0];
                    error_reg[i]  <= shreg[14];
                    parity_reg[i] <= ^shreg;
                    valid_reg[i]  <= seen_reg[i] & ~(^shreg);
                    seen_reg[i]   <= 1'b1;
                end
            end
            if (sweep_done) sweep_count <= sweep_count + 32'd1;
        end
    end

    always_comb begin
        read_mux = '0;
        for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
            if (address == 5'(i)) begin
                read_mux = {valid_reg[i], error_reg[i], parity_reg[i], 15'b0, angle_reg[i]};
            end
        end
        case (address)
            5'd16:   read_mux = {31'b0, enable};
            5'd17:   read_mux = sweep_count;
            5'd18:   read_mux = {27'b0, state != IDLE, index};
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable   <= 1'b0;
            readdata <= '0;
        end else begin
            if (write && address == 5'd16) enable <= writedata[0];
            if (read) readdata <= read_mux;
        end
    end
endmodule
